// File: rtl/store_align_unit_if.sv
// Store request / data bus bundle for store_align_unit.
// slave = the unit's view; master = the requester and bus environment driving it.
interface store_align_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [XLEN-1:0]   req_data;

    logic              bus_valid;
    logic              bus_ready;
    logic [ADDR_W-1:0] bus_addr;
    logic [XLEN-1:0]   bus_wdata;
    logic [NB-1:0]     bus_be;

    logic              done;
    logic              fault;

    modport master (
        output req_valid, req_addr, req_size, req_data, bus_ready,
        input  req_ready, bus_valid, bus_addr, bus_wdata, bus_be, done, fault
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_data, bus_ready,
        output req_ready, bus_valid, bus_addr, bus_wdata, bus_be, done, fault
    );
endinterface

// File: rtl/store_align_unit.sv
// Sequential store aligner: lane-aligns SB/SH/SW/SD data, builds byte enables, drives a
// valid/ready bus. Define STORE_ALIGN_MISALIGN_EN to split XLEN-crossing stores into two beats.
module store_align_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    store_align_unit_if.slave   sif
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int MW = 2 * NB;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t            state, state_nxt;
    logic [2*XLEN-1:0] wide_q, wide_d;
    logic [MW-1:0]     mask_q, mask_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;

    logic              accept;
    logic              hs;
    logic              aligned;
    logic              legal;
    logic [OW-1:0]     off;
    logic [3:0]        nbytes;
    logic [XLEN-1:0]   data_m;

    logic [ADDR_W-1:0] bus_addr;
    logic [XLEN-1:0]   bus_wdata;
    logic [NB-1:0]     bus_be;

    assign accept = sif.req_valid & sif.req_ready;
    assign hs     = sif.bus_valid & sif.bus_ready;
    assign off    = sif.req_addr[OW-1:0];
    assign nbytes = 4'd1 << sif.req_size;

    // Request decode: mask data to the access size and place it across two XLEN words.
    always_comb begin
        data_m = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(nbytes)) data_m[8*i +: 8] = sif.req_data[8*i +: 8];
        end
        wide_d = {{XLEN{1'b0}}, data_m} << {off, 3'b000};
        mask_d = MW'((32'd1 << nbytes) - 32'd1) << off;
        base_d = {sif.req_addr[ADDR_W-1:OW], {OW{1'b0}}};
    end

    always_comb begin
`ifdef STORE_ALIGN_MISALIGN_EN
        aligned = 1'b1;
`else
        aligned = (off & OW'(nbytes - 4'd1)) == '0;
`endif
        legal = aligned && !(XLEN == 32 && sif.req_size == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_d    = 1'b0;
        fault_d   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (legal) state_nxt = BEAT0;
                    else       fault_d   = 1'b1;
                end
            end
            BEAT0: begin
                if (hs) begin
                    if (mask_q[MW-1:NB] != '0) begin
                        state_nxt = BEAT1;
                    end else begin
                        state_nxt = IDLE;
                        done_d    = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (hs) begin
                    state_nxt = IDLE;
                    done_d    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Payload is captured once at accept and held until the final handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wide_q  <= '0;
            mask_q  <= '0;
            base_q  <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            done_q  <= done_d;
            fault_q <= fault_d;
            if (accept && legal) begin
                wide_q <= wide_d;
                mask_q <= mask_d;
                base_q <= base_d;
            end
        end
    end

    // Outputs decode from registered state only, so bus_ready never reaches them combinationally.
    always_comb begin
        bus_addr  = '0;
        bus_wdata = '0;
        bus_be    = '0;
        case (state)
            BEAT0: begin
                bus_addr  = base_q;
                bus_wdata = wide_q[XLEN-1:0];
                bus_be    = mask_q[NB-1:0];
            end
            BEAT1: begin
                bus_addr  = base_q + ADDR_W'(NB);
                bus_wdata = wide_q[2*XLEN-1:XLEN];
                bus_be    = mask_q[MW-1:NB];
            end
            default: ;
        endcase
    end

    assign sif.req_ready = (state == IDLE);
    assign sif.bus_valid = (state != IDLE);
    assign sif.bus_addr  = bus_addr;
    assign sif.bus_wdata = bus_wdata;
    assign sif.bus_be    = bus_be;
    assign sif.done      = done_q;
    assign sif.fault     = fault_q;
endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit (XLEN=32); misaligned-split cases only with STORE_ALIGN_MISALIGN_EN.
module tb_store_align_unit;
    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    store_align_unit_if #(.XLEN(32), .ADDR_W(32)) sif ();

    store_align_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_req(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        sif.req_valid = 1'b1;
        sif.req_addr  = addr;
        sif.req_size  = size;
        sif.req_data  = data;
    endtask

    task automatic test_reset;
        sif.req_valid = 1'b0; sif.req_addr = '0; sif.req_size = '0; sif.req_data = '0;
        sif.bus_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vecs++; if (sif.req_ready !== 1'b1) begin errs++; $display("FAIL rst_req_ready: got %b exp 1", sif.req_ready); end
        vecs++; if (sif.bus_valid !== 1'b0) begin errs++; $display("FAIL rst_bus_valid: got %b exp 0", sif.bus_valid); end
        vecs++; if (sif.done !== 1'b0 || sif.fault !== 1'b0) begin errs++; $display("FAIL rst_done_fault: got %b%b exp 00", sif.done, sif.fault); end
        vecs++; if (sif.bus_addr !== 32'h0 || sif.bus_wdata !== 32'h0 || sif.bus_be !== 4'h0) begin
            errs++; $display("FAIL rst_payload: got %h/%h/%b exp 0/0/0000", sif.bus_addr, sif.bus_wdata, sif.bus_be); end
        rst_n = 1'b1;
    endtask

    task automatic test_sb;
        @(negedge clk); drive_req(32'h1003, 2'd0, 32'h1234_5678);
        @(negedge clk); sif.req_valid = 1'b0;
        vecs++; if (sif.bus_valid !== 1'b1 || sif.req_ready !== 1'b0) begin errs++; $display("FAIL sb_valid: got v=%b r=%b exp v=1 r=0", sif.bus_valid, sif.req_ready); end
        vecs++; if (sif.bus_addr !== 32'h1000 || sif.bus_wdata !== 32'h7800_0000 || sif.bus_be !== 4'b1000) begin
            errs++; $display("FAIL sb_beat: got %h/%h/%b exp 00001000/78000000/1000", sif.bus_addr, sif.bus_wdata, sif.bus_be); end
        vecs++; if (sif.done !== 1'b0) begin errs++; $display("FAIL sb_done_early: got %b exp 0", sif.done); end
        @(negedge clk);
        vecs++; if (sif.done !== 1'b1 || sif.bus_valid !== 1'b0 || sif.req_ready !== 1'b1) begin
            errs++; $display("FAIL sb_done: got d=%b v=%b r=%b exp d=1 v=0 r=1", sif.done, sif.bus_valid, sif.req_ready); end
        @(negedge clk);
        vecs++; if (sif.done !== 1'b0) begin errs++; $display("FAIL sb_done_pulse: got %b exp 0", sif.done); end
    endtask

    task automatic test_stall;
        int dones;
        dones = 0;
        sif.bus_ready = 1'b0;
        @(negedge clk); drive_req(32'h2000, 2'd2, 32'h1234_5678);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); sif.req_valid = 1'b0;
            if (sif.done === 1'b1) dones++;
            vecs++; if (sif.bus_valid !== 1'b1 || sif.bus_addr !== 32'h2000 || sif.bus_wdata !== 32'h1234_5678 || sif.bus_be !== 4'b1111) begin
                errs++; $display("FAIL stall_hold[%0d]: got v=%b %h/%h/%b exp v=1 00002000/12345678/1111", c, sif.bus_valid, sif.bus_addr, sif.bus_wdata, sif.bus_be); end
        end
        sif.bus_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (sif.done === 1'b1) dones++;
        end
        vecs++; if (dones != 1) begin errs++; $display("FAIL stall_done_count: got %0d exp 1", dones); end
        vecs++; if (sif.bus_valid !== 1'b0) begin errs++; $display("FAIL stall_release: got %b exp 0", sif.bus_valid); end
    endtask

    task automatic test_illegal;
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs = '{32'h2003, 32'h1001, 32'h4000};
        sizes = '{2'd2, 2'd1, 2'd3};
        for (int k = 0; k < 3; k++) begin
`ifdef STORE_ALIGN_MISALIGN_EN
            if (k < 2) continue;
`endif
            @(negedge clk); drive_req(addrs[k], sizes[k], 32'h1234_5678);
            @(negedge clk); sif.req_valid = 1'b0;
            vecs++; if (sif.fault !== 1'b1 || sif.bus_valid !== 1'b0 || sif.done !== 1'b0 || sif.req_ready !== 1'b1) begin
                errs++; $display("FAIL illegal[%0d]: got f=%b v=%b d=%b r=%b exp f=1 v=0 d=0 r=1", k, sif.fault, sif.bus_valid, sif.done, sif.req_ready); end
            @(negedge clk);
            vecs++; if (sif.fault !== 1'b0 || sif.bus_valid !== 1'b0) begin
                errs++; $display("FAIL illegal_pulse[%0d]: got f=%b v=%b exp f=0 v=0", k, sif.fault, sif.bus_valid); end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); drive_req(32'h0000_0010, 2'd0, 32'h0000_00AA);
        @(negedge clk); drive_req(32'h0000_0022, 2'd1, 32'h0000_BEEF);
        vecs++; if (sif.bus_addr !== 32'h10 || sif.bus_wdata !== 32'h0000_00AA || sif.bus_be !== 4'b0001) begin
            errs++; $display("FAIL b2b_beat1: got %h/%h/%b exp 00000010/000000aa/0001", sif.bus_addr, sif.bus_wdata, sif.bus_be); end
        @(negedge clk);
        vecs++; if (sif.done !== 1'b1 || sif.req_ready !== 1'b1) begin errs++; $display("FAIL b2b_done1: got d=%b r=%b exp d=1 r=1", sif.done, sif.req_ready); end
        @(negedge clk); sif.req_valid = 1'b0;
        vecs++; if (sif.bus_valid !== 1'b1 || sif.bus_addr !== 32'h20 || sif.bus_wdata !== 32'hBEEF_0000 || sif.bus_be !== 4'b1100 || sif.done !== 1'b0) begin
            errs++; $display("FAIL b2b_beat2: got v=%b d=%b %h/%h/%b exp v=1 d=0 00000020/beef0000/1100", sif.bus_valid, sif.done, sif.bus_addr, sif.bus_wdata, sif.bus_be); end
        @(negedge clk);
        vecs++; if (sif.done !== 1'b1) begin errs++; $display("FAIL b2b_done2: got %b exp 1", sif.done); end
    endtask

`ifdef STORE_ALIGN_MISALIGN_EN
    task automatic test_split;
        logic [31:0] addrs [3], a0 [3], d0 [3], a1 [3], d1 [3];
        logic [1:0]  sizes [3];
        logic [3:0]  b0 [3], b1 [3];
        logic        two [3];
        addrs = '{32'h2003, 32'h1001, 32'hFFFF_FFFE};
        sizes = '{2'd2, 2'd1, 2'd2};
        a0 = '{32'h2000, 32'h1000, 32'hFFFF_FFFC};
        d0 = '{32'h7800_0000, 32'h0056_7800, 32'h5678_0000};
        b0 = '{4'b1000, 4'b0110, 4'b1100};
        two = '{1'b1, 1'b0, 1'b1};
        a1 = '{32'h2004, 32'h0, 32'h0000_0000};
        d1 = '{32'h0012_3456, 32'h0, 32'h0000_1234};
        b1 = '{4'b0111, 4'b0000, 4'b0011};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive_req(addrs[k], sizes[k], (k == 1) ? 32'hABCD_5678 : 32'h1234_5678);
            @(negedge clk); sif.req_valid = 1'b0;
            vecs++; if (sif.bus_valid !== 1'b1 || sif.bus_addr !== a0[k] || sif.bus_wdata !== d0[k] || sif.bus_be !== b0[k]) begin
                errs++; $display("FAIL split_b0[%0d]: got v=%b %h/%h/%b exp %h/%h/%b", k, sif.bus_valid, sif.bus_addr, sif.bus_wdata, sif.bus_be, a0[k], d0[k], b0[k]); end
            @(negedge clk);
            if (two[k]) begin
                vecs++; if (sif.bus_valid !== 1'b1 || sif.done !== 1'b0 || sif.bus_addr !== a1[k] || sif.bus_wdata !== d1[k] || sif.bus_be !== b1[k]) begin
                    errs++; $display("FAIL split_b1[%0d]: got v=%b d=%b %h/%h/%b exp %h/%h/%b", k, sif.bus_valid, sif.done, sif.bus_addr, sif.bus_wdata, sif.bus_be, a1[k], d1[k], b1[k]); end
                @(negedge clk);
            end
            vecs++; if (sif.done !== 1'b1 || sif.bus_valid !== 1'b0) begin
                errs++; $display("FAIL split_done[%0d]: got d=%b v=%b exp d=1 v=0", k, sif.done, sif.bus_valid); end
        end
    endtask
`endif

    task automatic test_reset_mid;
        int spurious;
        spurious = 0;
        sif.bus_ready = 1'b0;
        @(negedge clk); drive_req(32'h3000, 2'd2, 32'hCAFE_F00D);
        @(negedge clk); sif.req_valid = 1'b0;
        vecs++; if (sif.bus_valid !== 1'b1) begin errs++; $display("FAIL mid_stall: got %b exp 1", sif.bus_valid); end
        rst_n = 1'b0;
        #1;
        vecs++; if (sif.bus_valid !== 1'b0 || sif.req_ready !== 1'b1) begin
            errs++; $display("FAIL mid_rst_async: got v=%b r=%b exp v=0 r=1", sif.bus_valid, sif.req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sif.bus_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (sif.done !== 1'b0 || sif.fault !== 1'b0 || sif.bus_valid !== 1'b0) spurious++;
        end
        vecs++; if (spurious != 0 || sif.req_ready !== 1'b1) begin
            errs++; $display("FAIL mid_after: got spurious=%0d r=%b exp 0 r=1", spurious, sif.req_ready); end
        test_sb();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_sb();
        test_stall();
        test_illegal();
        test_back_to_back();
`ifdef STORE_ALIGN_MISALIGN_EN
        test_split();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
